// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction-fetch front end.
//
// Owns the PC, issues sequential fetches to a 1-cycle-latency instruction
// memory, buffers returned instructions in a DEPTH-entry queue and hands
// {instruction, pc} to decode over a valid/ready handshake. A branch redirect
// flushes everything in flight and restarts fetch at the target; a hazard
// stall only blocks new fetches.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   hz_stall              block new fetches while high
//   br_valid, br_target   redirect request and target address
//   imem_en, imem_addr    fetch request / address (address = current PC)
//   imem_rdata            instruction data, valid the cycle after imem_en
//   dec_valid/dec_ready   head-of-queue handshake to decode
//   dec_instr, dec_pc     head instruction and its address
//
// Optional: define FETCH_PERF_EN to add saturating 32-bit counters
//   perf_fetch_cnt (fetches issued) and perf_flush_cnt (redirect cycles).
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                PC_STEP  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hz_stall,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_pc    [DEPTH];

    logic               issue;
    logic               pop;
    logic [CNT_W:0]     occupancy;

    // An in-flight fetch has a reserved slot: counting it here is what makes
    // an unconditional capture on the next edge safe.
    // NOTE: combinational blocks use blocking '=' and assign every output
    // first, so no latch is inferred and reads see the freshly computed value.
    always_comb begin
        occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
        issue     = reset && !br_valid && !hz_stall &&
                    (occupancy < (CNT_W + 1)'(DEPTH));
    end

    assign imem_en   = issue;
    assign imem_addr = pc;
    assign dec_valid = (count != '0);
    assign pop       = dec_valid && dec_ready;
    assign dec_instr = q_instr[rd_ptr];
    assign dec_pc    = q_pc[rd_ptr];

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (br_valid) begin
            // Redirect wins over everything: drop queued and returning data.
            pc       <= br_target;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + ADDR_W'(PC_STEP);
                inflight_pc <= pc;
            end
            if (inflight) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
            case ({inflight, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage is deliberately not reset; count and the pointers
    // decide which entries are live, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (inflight && !br_valid) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (imem_en && (perf_fetch_cnt != '1))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (br_valid && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- scoreboard bench for fetch_unit.
//
// A reference model tracks the architectural PC and the ordered list of
// fetches that are still owed to decode (in flight or buffered). Each issued
// fetch pushes its expected {instr, pc} into a queue; a separate monitor pops
// and compares whenever decode takes an instruction. The memory model
// returns addr ^ 16'hA5A5. A second instance checks RESET_PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hz_stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [15:0] br_target = '0;
    logic [15:0] imem_rdata = '0;
    logic        dec_ready = 1'b0;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic        dec_valid;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;

    logic        w_zero = 1'b0;
    logic        w_one = 1'b1;
    logic [15:0] w_target = '0;
    logic [15:0] w_rdata = '0;
    logic        w_imem_en;
    logic [15:0] w_imem_addr;
    logic        w_dec_valid;
    logic [15:0] w_dec_instr;
    logic [15:0] w_dec_pc;
    logic        w_last_en = 1'b0;
    logic [15:0] w_last_addr = '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt;
    logic [31:0] w_perf_fetch_cnt, w_perf_flush_cnt;
    int          m_fetch = 0;
    int          m_flush = 0;
`endif

    exp_t        exp_q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] m_pc = '0;
    logic        m_issue = 1'b0;
    logic        exp_en;
    logic        exp_valid;
    logic        last_en = 1'b0;
    logic [15:0] last_addr = '0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .PC_STEP(2), .RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .hz_stall(hz_stall), .br_valid(br_valid), .br_target(br_target),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .PC_STEP(2), .RESET_PC(16'hFFFE), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset), .hz_stall(w_zero), .br_valid(w_zero), .br_target(w_target),
        .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_rdata),
        .dec_valid(w_dec_valid), .dec_ready(w_one), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(w_perf_fetch_cnt), .perf_flush_cnt(w_perf_flush_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus shortly after the rising edge; the memory
    // answers whatever the DUT requested in the previous cycle.
    task automatic drive(input logic rst, input logic stall, input logic br,
                         input logic [15:0] tgt, input logic rdy);
        @(posedge clk);
        #1;
        reset      = rst;
        hz_stall   = stall;
        br_valid   = br;
        br_target  = tgt;
        dec_ready  = rdy;
        imem_rdata = last_en ? (last_addr ^ 16'hA5A5) : 16'($urandom);
    endtask

    // Reference model: advance the architectural state at each edge.
    initial forever begin
        @(posedge clk);
        if (!reset) begin
            exp_q.delete();
            m_pc = 16'h0000;
`ifdef FETCH_PERF_EN
            m_fetch = 0;
            m_flush = 0;
`endif
        end else if (br_valid) begin
            exp_q.delete();
            m_pc = br_target;
`ifdef FETCH_PERF_EN
            m_flush++;
`endif
        end else if (m_issue) begin
            exp_q.push_back('{instr: m_pc ^ 16'hA5A5, pc: m_pc, cyc: cyc});
            m_pc = m_pc + 16'd2;
`ifdef FETCH_PERF_EN
            m_fetch++;
`endif
        end
        m_issue = 1'b0;
        cyc++;
    end

    // Per-cycle check of the fetch request and head-valid timing. Everything
    // owed to decode occupies a slot, so the queue size is the occupancy.
    initial forever begin
        @(posedge clk);
        #3;
        exp_en    = reset && !br_valid && !hz_stall && (exp_q.size() < DEPTH);
        exp_valid = 1'b0;
        if (reset && exp_q.size() > 0)
            exp_valid = (cyc >= exp_q[0].cyc + 2);
        check("imem_en", imem_en, exp_en);
        if (reset) check("imem_addr", imem_addr, m_pc);
        check("dec_valid", dec_valid, exp_valid);
        m_issue   = exp_en;
        last_en   = imem_en;
        last_addr = imem_addr;
    end

    // Monitor: every accepted instruction must be the oldest one still owed.
    initial forever begin
        @(negedge clk);
        if (reset && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dec_unexpected: got pc %0h, expected nothing (t=%0t)", dec_pc, $time);
            end else begin
                e = exp_q.pop_front();
                check("dec_pc", dec_pc, e.pc);
                check("dec_instr", dec_instr, e.instr);
            end
        end
    end

    // Memory model for the wrap-around instance.
    initial forever begin
        @(posedge clk);
        #1;
        w_rdata = w_last_en ? (w_last_addr ^ 16'hA5A5) : 16'h0000;
        #2;
        w_last_en   = w_imem_en;
        w_last_addr = w_imem_addr;
    end

    // RESET_PC=FFFE: addresses wrap FFFE -> 0000 -> 0002.
    initial begin
        logic [15:0] w_exp [4];
        w_exp[0] = 16'hFFFE;
        w_exp[1] = 16'h0000;
        w_exp[2] = 16'h0002;
        w_exp[3] = 16'h0004;
        wait (reset == 1'b1);
        #3;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #4;
            end
            check("wrap_imem_en", w_imem_en, 1'b1);
            check("wrap_imem_addr", w_imem_addr, w_exp[k]);
            if (k >= 2) begin
                check("wrap_dec_valid", w_dec_valid, 1'b1);
                check("wrap_dec_pc", w_dec_pc, w_exp[k-2]);
                check("wrap_dec_instr", w_dec_instr, w_exp[k-2] ^ 16'hA5A5);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        r_br, r_stall, r_rdy;
        logic [15:0] r_tgt;

        // Reset state.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        #1;
        check("rst_imem_en", imem_en, 1'b0);
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_imem_addr", imem_addr, 16'h0000);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

        // Decode back-pressure: fill to four outstanding, then stop at pc 8.
        repeat (10) drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        #3;
        check("full_imem_en", imem_en, 1'b0);
        check("full_imem_addr", imem_addr, 16'h0008);
        check("full_dec_valid", dec_valid, 1'b1);
        check("full_dec_pc", dec_pc, 16'h0000);
        repeat (8) drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Redirect with two queued and one in flight.
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        #3;
        check("br_dec_valid", dec_valid, 1'b0);
        check("br_imem_addr", imem_addr, 16'h0100);
        check("br_imem_en", imem_en, 1'b1);
        repeat (6) drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Hazard stall during streaming, then a redirect under stall.
        repeat (3) drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 16'h0200, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            r_br    = ($urandom_range(15) == 0);
            r_stall = ($urandom_range(4) == 0);
            r_rdy   = ($urandom_range(3) != 0);
            r_tgt   = 16'($urandom) & 16'hFFFE;
            drive(1'b1, r_stall, r_br, r_tgt, r_rdy);
        end
`ifdef FETCH_PERF_EN
        #3;
        check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
        check("perf_flush_cnt", perf_flush_cnt, m_flush);
`endif

        // Asynchronous reset mid-stream with entries queued.
        repeat (4) drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        #1;
        check("mid_rst_dec_valid", dec_valid, 1'b0);
        check("mid_rst_imem_en", imem_en, 1'b0);
        check("mid_rst_imem_addr", imem_addr, 16'h0000);
`ifdef FETCH_PERF_EN
        check("mid_rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("mid_rst_perf_flush", perf_flush_cnt, 32'd0);
        check("mid_rst_wrap_perf_fetch", w_perf_fetch_cnt, 32'd0);
        check("mid_rst_wrap_perf_flush", w_perf_flush_cnt, 32'd0);
`endif
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        #3;
        check("restart_imem_addr", imem_addr, 16'h0000);
        repeat (10) drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        @(posedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the CPU datapath.
- Owns the PC register, next-address increment, branch redirect and hazard hold.
- Drives a 1-cycle-latency instruction memory and buffers returned instructions in a small queue.
- Presents {instruction, pc} to decode with a valid/ready handshake.

Parameters:
ADDR_W, 16, PC/address width in bits
INSTR_W, 16, instruction width in bits
PC_STEP, 2, PC increment per sequential fetch
RESET_PC, 0, PC value loaded on reset
DEPTH, 4, instruction queue entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
hz_stall  input  1  hazard hold: no new fetch issued while high
br_valid  input  1  branch redirect request
br_target  input  ADDR_W  redirect address
imem_en  output  1  fetch request this cycle
imem_addr  output  ADDR_W  fetch address (= current PC)
imem_rdata  input  INSTR_W  instruction data, valid the cycle after imem_en
dec_valid  output  1  queue head valid
dec_ready  input  1  decode accepts head
dec_instr  output  INSTR_W  head instruction
dec_pc  output  ADDR_W  address of head instruction

Behaviour:
- State: pc register, inflight flag plus inflight_pc, DEPTH-entry queue of {instr, pc}, rd/wr pointers, count (0..DEPTH).
- Reset (reset==0, asynchronous): pc=RESET_PC, count=0, pointers=0, inflight=0. Outputs: imem_en=0, dec_valid=0, imem_addr=RESET_PC. Reset mid-operation discards all queued and in-flight data.
- Issue condition: reset high, !br_valid, !hz_stall, and (count + inflight) < DEPTH.
  - Outputs: imem_en=1, imem_addr=pc.
  - Next edge: pc <= pc + PC_STEP, modulo 2^ADDR_W (wraps silently); inflight <= 1; inflight_pc <= pc.
  - When not issuing: inflight <= 0 and pc holds.
- Capture: if inflight==1 at an edge, {imem_rdata, inflight_pc} is written at wr_ptr and count increments. The space check guarantees no write when full.
- Dequeue: dec_valid = (count != 0). dec_instr/dec_pc are taken combinationally from the rd_ptr entry. A transfer occurs when dec_valid && dec_ready; rd_ptr advances and count decrements.
- Simultaneous capture and dequeue: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Redirect (br_valid=1), highest priority, overrides hz_stall:
  - Same cycle: imem_en=0.
  - Next edge: pc <= br_target, queue flushed (count=0, pointers=0), inflight <= 0. Data returning that cycle is dropped.
  - A dec_valid && dec_ready transfer in the redirect cycle counts as completed.
  - First fetch from br_target is issued the following cycle, provided br_valid and hz_stall are low.
- hz_stall: holds pc and blocks issue only. An already in-flight fetch is still captured, and the queue still drains.
- Latency: issue in cycle N, capture at end of N+1, dec_valid high in N+2. Steady state delivers 1 instruction/cycle with continuous dec_ready.
- br_target alignment is not checked; it is used as given.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds outputs:
  - perf_fetch_cnt (32-bit): increments on each imem_en.
  - perf_flush_cnt (32-bit): increments on each br_valid cycle.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, dec_ready=1, memory returns addr^16'hA5A5 → imem_addr 0,2,4,6... on consecutive cycles; first dec_valid 2 cycles after the first imem_en; dec_pc 0,2,4 in order with matching data.
- dec_ready=0 for 10 cycles → exactly 4 entries buffered, imem_en stops at count+inflight=4, pc holds at 8. Raise dec_ready → instructions at pc 0..6 delivered in order, fetching resumes at 8.
- br_valid with br_target=16'h0100 while 2 entries are queued and 1 fetch is in flight → queue empties next cycle, in-flight data discarded, next imem_addr=0x0100, first dec_pc=0x0100.
- hz_stall high for 3 cycles during streaming → no imem_en for 3 cycles, pc frozen, the in-flight instruction is still delivered; br_valid during the stall still redirects.
- Start at pc 16'hFFFE (RESET_PC override) → imem_addr sequence FFFE, 0000, 0002.
- Assert reset mid-stream with 3 queued → dec_valid=0 and imem_en=0 immediately (asynchronous); after release, fetching restarts at RESET_PC. With FETCH_PERF_EN, both counters read 0.
